// File: rtl/vga_sync_gen.sv
// Raster timing generator: free-running pixel/line counters with registered sync,
// display-enable, coordinate and strobe outputs, all aligned one clock behind the counters.
module vga_sync_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic        clk_148_mhz,
    input  logic        rst_n,
    output logic        hsync,
    output logic        vsync,
    output logic        display_on,
    output logic [11:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Decode bounds are one bit wider than the counters so a sync pulse ending
    // exactly at a full-width total cannot wrap to zero.
    localparam logic [12:0] H_ACT_W  = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG_W = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END_W = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG_W = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END_W = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        h_wrap;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        line_q, line_d;
    logic        frame_q, frame_d;
    logic [11:0] px_q;
    logic [10:0] py_q;

    logic [12:0] h_ext;
    logic [11:0] v_ext;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        end
    end

    always_comb begin
        h_ext   = {1'b0, h_cnt_q};
        v_ext   = {1'b0, v_cnt_q};
        de_d    = (h_ext < H_ACT_W) && (v_ext < V_ACT_W);
        hsync_d = ((h_ext >= HS_BEG_W) && (h_ext < HS_END_W)) ? H_POL : ~H_POL;
        vsync_d = ((v_ext >= VS_BEG_W) && (v_ext < VS_END_W)) ? V_POL : ~V_POL;
        line_d  = (h_cnt_q == 12'd0);
        frame_d = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);
    end

    always_ff @(posedge clk_148_mhz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 11'd0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            px_q    <= 12'd0;
            py_q    <= 11'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            px_q    <= h_cnt_q;
            py_q    <= v_cnt_q;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = de_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for line timing and a small-parameter
// instance for frame timing, vectors and randomized resets against a position model.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;

    logic        hs_a, vs_a, de_a, ls_a, fs_a;
    logic [11:0] px_a;
    logic [10:0] py_a;
    logic        hs_b, vs_b, de_b, ls_b, fs_b;
    logic [11:0] px_b;
    logic [10:0] py_b;

    vga_sync_gen u_full (
        .clk_148_mhz(clk), .rst_n(rst_a_n),
        .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
        .pixel_x(px_a), .pixel_y(py_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0)
    ) u_small (
        .clk_148_mhz(clk), .rst_n(rst_b_n),
        .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
        .pixel_x(px_b), .pixel_y(py_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    logic [27:0] out_a, out_b;
    assign out_a = {hs_a, vs_a, de_a, ls_a, fs_a, px_a, py_a};
    assign out_b = {hs_b, vs_b, de_b, ls_b, fs_b, px_b, py_b};

    int n_vec = 0;
    int n_err = 0;
    int ka = 0;   // rising edges seen since instance A left reset (0 = in reset)
    int kb = 0;

    function automatic logic [27:0] pk(bit hs, bit vs, bit de, bit ls, bit fs, int x, int y);
        return {hs, vs, de, ls, fs, 12'(x), 11'(y)};
    endfunction

    // Expected outputs after k edges out of reset: position is simply (k-1) mod frame.
    function automatic logic [27:0] model(int k, int ha, int hf, int hsw, int hb,
                                          int va, int vf, int vsw, int vb, bit hp, bit vp);
        int ht, vt, p, x, y;
        bit hs, vs;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (k == 0) return pk(~hp, ~vp, 1'b0, 1'b0, 1'b0, 0, 0);
        p  = (k - 1) % (ht * vt);
        x  = p % ht;
        y  = p / ht;
        hs = ((x >= ha + hf) && (x < ha + hf + hsw)) ? hp : ~hp;
        vs = ((y >= va + vf) && (y < va + vf + vsw)) ? vp : ~vp;
        return pk(hs, vs, (x < ha) && (y < va), x == 0, (x == 0) && (y == 0), x, y);
    endfunction

    function automatic logic [27:0] model_a(int k);
        return model(k, 1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1);
    endfunction

    function automatic logic [27:0] model_b(int k);
        return model(k, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {hs,vs,de,ls,fs,x,y}=%0b%0b%0b%0b%0b,%0d,%0d expected %0b%0b%0b%0b%0b,%0d,%0d",
                     nm, act[27], act[26], act[25], act[24], act[23], act[22:11], act[10:0],
                     exp[27], exp[26], exp[25], exp[24], exp[23], exp[22:11], exp[10:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_a_n) ka++;
        if (rst_b_n) kb++;
        @(negedge clk);
    endtask

    typedef struct {
        int          k;
        logic [27:0] exp;
    } vec_t;

    vec_t vt[16];

    initial begin
        int prev_hs, de_cnt, hs_cnt, first_low, hs_rise_x, ls1, ls2, ls_cnt;
        int fs1, fs2, fs_cnt, vs_cnt, vs_first_x, vs_first_y;

        // Small instance: HT=14, VT=7, both syncs active-low.
        vt[0]  = '{1,  pk(1,1,1,1,1, 0,0)};
        vt[1]  = '{8,  pk(1,1,1,0,0, 7,0)};
        vt[2]  = '{9,  pk(1,1,0,0,0, 8,0)};
        vt[3]  = '{11, pk(0,1,0,0,0,10,0)};
        vt[4]  = '{12, pk(0,1,0,0,0,11,0)};
        vt[5]  = '{13, pk(1,1,0,0,0,12,0)};
        vt[6]  = '{14, pk(1,1,0,0,0,13,0)};
        vt[7]  = '{15, pk(1,1,1,1,0, 0,1)};
        vt[8]  = '{57, pk(1,1,0,1,0, 0,4)};
        vt[9]  = '{70, pk(1,1,0,0,0,13,4)};
        vt[10] = '{71, pk(1,0,0,1,0, 0,5)};
        vt[11] = '{81, pk(0,0,0,0,0,10,5)};
        vt[12] = '{84, pk(1,0,0,0,0,13,5)};
        vt[13] = '{85, pk(1,1,0,1,0, 0,6)};
        vt[14] = '{98, pk(1,1,0,0,0,13,6)};
        vt[15] = '{99, pk(1,1,1,1,1, 0,0)};

        repeat (10) tick();
        chk("reset_full", out_a, pk(0,0,0,0,0,0,0));
        chk("reset_small", out_b, pk(1,1,0,0,0,0,0));

        rst_b_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            while (kb < vt[i].k) tick();
            chk($sformatf("vec_small_k%0d", vt[i].k), out_b, vt[i].exp);
        end
        chk("full_held_in_reset", out_a, pk(0,0,0,0,0,0,0));

        // Full-size instance: two complete lines.
        rst_a_n = 1'b1;
        prev_hs = 0; de_cnt = 0; hs_cnt = 0; first_low = -1; hs_rise_x = -1;
        ls1 = -1; ls2 = -1; ls_cnt = 0;
        for (int i = 1; i <= 4400; i++) begin
            tick();
            if (i == 1) chk("full_release", out_a, pk(0,0,1,1,1,0,0));
            chk($sformatf("full_k%0d", ka), out_a, model_a(ka));
            if (de_a) de_cnt++;
            else if (first_low < 0) first_low = i - 1;
            if (hs_a) hs_cnt++;
            if (hs_a && prev_hs == 0 && hs_rise_x < 0) hs_rise_x = int'(px_a);
            prev_hs = int'(hs_a);
            if (ls_a) begin
                ls_cnt++;
                if (ls1 < 0) ls1 = i;
                else if (ls2 < 0) ls2 = i;
            end
        end
        chk_int("de_first_run", first_low, 1920);
        chk_int("de_count_2lines", de_cnt, 3840);
        chk_int("hs_count_2lines", hs_cnt, 88);
        chk_int("hs_rise_x", hs_rise_x, 2008);
        chk_int("ls_count", ls_cnt, 2);
        chk_int("ls_period", ls2 - ls1, 2200);

        // Mid-frame asynchronous reset on the full instance at (700,2).
        while (ka < 2 * 2200 + 701) tick();
        chk("full_pre_reset", out_a, pk(0,0,1,0,0,700,2));
        rst_a_n = 1'b0;
        ka = 0;
        #1;
        chk("full_midreset_async", out_a, pk(0,0,0,0,0,0,0));
        tick(); tick();
        rst_a_n = 1'b1;
        tick();
        chk("full_restart", out_a, pk(0,0,1,1,1,0,0));

        // Small instance: two full frames from a fresh reset.
        rst_b_n = 1'b0;
        kb = 0;
        tick();
        rst_b_n = 1'b1;
        fs1 = -1; fs2 = -1; fs_cnt = 0; vs_cnt = 0; de_cnt = 0; hs_cnt = 0;
        vs_first_x = -1; vs_first_y = -1;
        for (int i = 1; i <= 196; i++) begin
            tick();
            chk($sformatf("small_k%0d", kb), out_b, model_b(kb));
            if (fs_b) begin
                fs_cnt++;
                if (fs1 < 0) fs1 = i;
                else if (fs2 < 0) fs2 = i;
            end
            if (!vs_b) begin
                vs_cnt++;
                if (vs_first_x < 0) begin
                    vs_first_x = int'(px_b);
                    vs_first_y = int'(py_b);
                end
            end
            if (!hs_b) hs_cnt++;
            if (de_b) de_cnt++;
        end
        chk_int("small_fs_count", fs_cnt, 2);
        chk_int("small_frame_period", fs2 - fs1, 98);
        chk_int("small_vs_low_count", vs_cnt, 28);
        chk_int("small_vs_start_x", vs_first_x, 0);
        chk_int("small_vs_start_y", vs_first_y, 5);
        chk_int("small_hs_low_count", hs_cnt, 28);
        chk_int("small_de_count", de_cnt, 64);

        // Randomized run lengths and asynchronous reset pulses on the small instance.
        for (int it = 0; it < 40; it++) begin
            int n;
            n = int'($urandom_range(1, 250));
            repeat (n) begin
                tick();
                chk($sformatf("rand_k%0d", kb), out_b, model_b(kb));
            end
            if ($urandom_range(0, 2) == 0) begin
                #($urandom_range(1, 3));
                rst_b_n = 1'b0;
                kb = 0;
                #1;
                chk("rand_reset_async", out_b, model_b(0));
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    chk("rand_in_reset", out_b, model_b(0));
                end
                rst_b_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
